// File: rtl/iob_cache_ctrl_seq.sv
// iob_cache_ctrl_seq: start-triggered flush/invalidate/reset-counters sequencer for the cache control CSR port
module iob_cache_ctrl_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int WTB_EMPTY_ADDR = 0,
    parameter int INVALIDATE_ADDR = 1,
    parameter int RST_CNTRS_ADDR = 2,
    parameter int POLL_MAX = 1023,
    localparam int WSTRB_W = DATA_W / 8,
    localparam int BYTE_SHIFT = $clog2(WSTRB_W),
    localparam int CNT_W = $clog2(POLL_MAX + 1)
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [2:0]         cmd_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [WSTRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0]  wdata_o,
    input  logic [DATA_W-1:0]  rdata_i,
    input  logic               ready_i
);
    typedef enum logic [2:0] {IDLE, FL_REQ, FL_WAIT, INV_REQ, INV_WAIT, RST_REQ, RST_WAIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] A_WTB = ADDR_W'(WTB_EMPTY_ADDR);
    localparam logic [ADDR_W-1:0] A_INV = ADDR_W'(INVALIDATE_ADDR);
    localparam logic [ADDR_W-1:0] A_RST = ADDR_W'(RST_CNTRS_ADDR);
    localparam logic [CNT_W-1:0]  POLL_CNT = CNT_W'(POLL_MAX);

    state_t             state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d, is_wr;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               unused_rdata;

    assign unused_rdata = ^rdata_i[DATA_W-1:1];

    // Lowest-order enabled step in flush -> invalidate -> reset-counters order.
    function automatic state_t first_step(input logic [2:0] c);
        return c[0] ? FL_REQ : c[1] ? INV_REQ : c[2] ? RST_REQ : DONE;
    endfunction

    // Next state, poll counter and error; outputs are precomputed from the next state so they come out registered.
    always_comb begin
        state_d = state_q;
        cmd_d = cmd_q;
        cnt_d = cnt_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (start_i) begin
                cmd_d = cmd_i[2:1];
                cnt_d = '0;
                err_d = 1'b0;
                state_d = first_step(cmd_i);
            end
            FL_REQ: state_d = FL_WAIT;
            FL_WAIT: if (ready_i) begin
                if (rdata_i[0]) state_d = first_step({cmd_q, 1'b0});
                else begin
                    cnt_d = cnt_q + 1'b1;
                    err_d = cnt_d == POLL_CNT;
                    state_d = err_d ? DONE : FL_REQ;
                end
            end
            INV_REQ: state_d = INV_WAIT;
            INV_WAIT: if (ready_i) state_d = first_step({cmd_q[1], 2'b00});
            RST_REQ: state_d = RST_WAIT;
            RST_WAIT: if (ready_i) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        is_wr = state_d == INV_REQ || state_d == RST_REQ;
        valid_d = state_d == FL_REQ || is_wr;
        addr_d = state_d == FL_REQ ? A_WTB : state_d == INV_REQ ? A_INV : state_d == RST_REQ ? A_RST : addr_q;
        wstrb_d = is_wr ? WSTRB_W'(1) << addr_d[BYTE_SHIFT-1:0] : '0;
        wdata_d = {DATA_W{is_wr}};
        busy_d = state_d != IDLE && state_d != DONE;
        done_d = state_d == DONE;
    end

    // State and registered outputs; reset wins over the clock enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cmd_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            valid_q <= 1'b0;
            addr_q <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            cmd_q <= cmd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            valid_q <= valid_d;
            addr_q <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign error_o = err_q;
    assign valid_o = valid_q;
    assign addr_o = addr_q;
    assign wstrb_o = wstrb_q;
    assign wdata_o = wdata_q;
endmodule

// File: tb/tb_iob_cache_ctrl_seq.sv
// tb_iob_cache_ctrl_seq: directed sequences checked per cycle against a transaction-list model of the sequencer
module tb_iob_cache_ctrl_seq;
    logic clk = 0, rst = 1, cke = 1, start = 0, lat2 = 0, sel = 0, run = 0;
    logic [2:0] cmd = 0;
    logic ready;
    logic [31:0] rdata;
    logic b0, d0, e0, v0, b1, d1, e1, v1;
    logic [4:0] a0, a1;
    logic [3:0] s0, s1;
    logic [31:0] w0, w1;
    logic busy_s, done_s, error_s, valid_s;
    logic [4:0] addr_s;
    logic [3:0] wstrb_s;
    logic [31:0] wdata_s;
    int checks = 0, errors = 0;
    int ecount = 0, t0 = 0, cur_empty = 0, npoll = 0;
    int exp_nr, exp_n, exp_done, nval = 0, last_done = -1;
    logic exp_err;
    logic [4:0] wa[$];
    logic [3:0] ws[$];
    logic r1 = 0, r2 = 0, pv = 0;
    int cyc, idx;
    logic ev;

    always #5 clk = ~clk;

    iob_cache_ctrl_seq dut0 (.clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start & ~sel), .cmd_i(cmd),
        .busy_o(b0), .done_o(d0), .error_o(e0), .valid_o(v0), .addr_o(a0), .wstrb_o(s0), .wdata_o(w0),
        .rdata_i(rdata), .ready_i(ready));
    iob_cache_ctrl_seq #(.POLL_MAX(3)) dut1 (.clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(start & sel), .cmd_i(cmd),
        .busy_o(b1), .done_o(d1), .error_o(e1), .valid_o(v1), .addr_o(a1), .wstrb_o(s1), .wdata_o(w1),
        .rdata_i(rdata), .ready_i(ready));

    assign busy_s = sel ? b1 : b0;
    assign done_s = sel ? d1 : d0;
    assign error_s = sel ? e1 : e0;
    assign valid_s = sel ? v1 : v0;
    assign addr_s = sel ? a1 : a0;
    assign wstrb_s = sel ? s1 : s0;
    assign wdata_s = sel ? w1 : w0;

    // Responder: acks every valid one (or two) enabled cycles later; buffer reads empty from poll cur_empty on.
    always @(posedge clk) begin
        if (cke) begin
            ecount <= ecount + 1;
            r1 <= valid_s;
            r2 <= r1;
            npoll <= (start && !busy_s) ? 0 : npoll + ((valid_s && wstrb_s == 4'b0) ? 1 : 0);
        end
    end
    assign ready = lat2 ? r2 : r1;
    assign rdata = {31'b0, cur_empty != 0 && npoll >= cur_empty};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Expected transaction list: polls until empty or POLL_MAX, then enabled writes unless timed out.
    task automatic plan(input logic [2:0] c, input int ea, input int pm);
        wa.delete();
        ws.delete();
        exp_nr = 0;
        exp_err = 0;
        if (c[0]) begin
            if (ea != 0 && ea <= pm) exp_nr = ea;
            else begin
                exp_nr = pm;
                exp_err = 1;
            end
        end
        if (!exp_err && c[1]) begin wa.push_back(5'd1); ws.push_back(4'b0010); end
        if (!exp_err && c[2]) begin wa.push_back(5'd2); ws.push_back(4'b0100); end
        exp_n = exp_nr + wa.size();
        exp_done = 1 + 2 * exp_n;
    endtask

    // Per-cycle compare against the model timeline (cycle index advances only on enabled edges).
    always @(negedge clk) begin
        cyc = ecount - t0;
        if (run && cyc >= 1) begin
            ev = (cyc % 2 == 1) && ((cyc - 1) / 2 < exp_n);
            chk("valid", valid_s, ev);
            if (ev) begin
                idx = (cyc - 1) / 2;
                chk("addr", addr_s, idx < exp_nr ? 5'd0 : wa[idx - exp_nr]);
                chk("wstrb", wstrb_s, idx < exp_nr ? 4'd0 : ws[idx - exp_nr]);
                chk("wdata", wdata_s, idx < exp_nr ? 32'd0 : 32'hffff_ffff);
            end
            chk("busy", busy_s, cyc < exp_done);
            chk("done", done_s, cyc == exp_done);
            chk("error", error_s, cyc >= exp_done ? exp_err : 1'b0);
            if (done_s) last_done = cyc;
        end
        if (valid_s && !pv) nval++;
        pv = valid_s;
    end

    task automatic run_seq(input bit s, input logic [2:0] c, input int ea, input int pm, input bit poke, input bit frz);
        int k = 0;
        bit fz = 0;
        @(posedge clk); #1;
        sel = s;
        cur_empty = ea;
        plan(c, ea, pm);
        t0 = ecount;
        start = 1;
        cmd = c;
        run = 1;
        while (ecount - t0 <= exp_done + 1 && k < 5000) begin
            @(posedge clk); #1;
            k++;
            start = 0;
            cmd = 3'($urandom_range(0, 7));
            if (poke && ecount - t0 == 3) begin start = 1; cmd = 3'b001; end
            if (frz && !fz && ecount - t0 == 1) begin
                fz = 1;
                cke = 0;
                repeat (5) @(posedge clk);
                #1 cke = 1;
            end
        end
        if (k >= 5000) chk("seq_timeout", 1, 0);
        start = 0;
        run = 0;
    endtask

    initial begin
        int nv;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        nv = nval;
        repeat (6) begin
            @(negedge clk);
            chk("idle_valid", v0, 0);
            chk("idle_busy", b0, 0);
            chk("idle_done", d0, 0);
            chk("idle_error", e0, 0);
            chk("idle_addr", a0, 0);
            chk("idle_wstrb", s0, 0);
            chk("idle_wdata", w0, 0);
        end
        chk("idle_no_valid", nval - nv, 0);

        nv = nval;
        run_seq(0, 3'b111, 1, 1023, 1, 0);
        chk("all_ntx", nval - nv, 3);
        chk("all_done_cyc", last_done, 7);

        nv = nval;
        run_seq(0, 3'b001, 4, 1023, 0, 0);
        chk("poll4_ntx", nval - nv, 4);
        chk("poll4_done_cyc", last_done, 9);

        nv = nval;
        run_seq(1, 3'b111, 0, 3, 0, 0);
        chk("tmo_ntx", nval - nv, 3);
        chk("tmo_done_cyc", last_done, 7);
        chk("tmo_error", e1, 1);

        nv = nval;
        run_seq(1, 3'b000, 0, 3, 0, 0);
        chk("nop_ntx", nval - nv, 0);
        chk("nop_done_cyc", last_done, 1);
        chk("nop_error", e1, 0);

        nv = nval;
        run_seq(0, 3'b110, 0, 1023, 0, 0);
        chk("wr_only_ntx", nval - nv, 2);

        begin
            int k = 0;
            @(posedge clk); #1;
            sel = 0;
            lat2 = 1;
            cur_empty = 1;
            start = 1;
            cmd = 3'b111;
            @(posedge clk); #1 start = 0;
            while (!(v0 && a0 == 5'd1) && k < 50) begin @(negedge clk); k++; end
            chk("rst_reach_inv", k < 50, 1);
            @(posedge clk); #1 rst = 1;
            @(posedge clk); #1 rst = 0;
            repeat (2) begin
                @(negedge clk);
                chk("rst_valid", v0, 0);
                chk("rst_busy", b0, 0);
                chk("rst_done", d0, 0);
                chk("rst_addr", a0, 0);
                chk("rst_wstrb", s0, 0);
                chk("rst_error", e0, 0);
            end
            lat2 = 0;
        end

        nv = nval;
        run_seq(0, 3'b111, 1, 1023, 0, 0);
        chk("post_rst_ntx", nval - nv, 3);

        nv = nval;
        run_seq(0, 3'b111, 1, 1023, 0, 1);
        chk("frz_ntx", nval - nv, 3);
        chk("frz_done_cyc", last_done, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
